// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs show-ahead byte FIFO entries into wide words with flush/timeout
//
// Read-side consumer of the byte FIFO. Entries are popped through the
// show-ahead port and packed into NBYTES-lane words, with the first popped
// entry in lane 0. A partial word is emitted on an explicit flush or after
// TIMEOUT idle cycles.
//
// Ports:
//   rclk      read-domain clock, rising edge
//   rst       synchronous active-high reset
//   rdata     FIFO head entry, valid when rempty=0
//   rempty    FIFO empty flag
//   rinc      pop request (combinational)
//   flush     emit the partial word now
//   out_data  packed word, lane 0 in the LSBs, unused lanes zero
//   out_keep  contiguous lane-valid mask starting at lane 0
//   out_valid word available (registered state, independent of out_ready)
//   out_ready downstream accepts the word while out_valid=1
module fifo_word_packer #(
  parameter int DSIZE   = 8,
  parameter int NBYTES  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      rclk,
  input  logic                      rst,
  input  logic [DSIZE-1:0]          rdata,
  input  logic                      rempty,
  output logic                      rinc,
  input  logic                      flush,
  output logic [DSIZE*NBYTES-1:0]   out_data,
  output logic [NBYTES-1:0]         out_keep,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int CW = $clog2(NBYTES) + 1;
  localparam int IW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(NBYTES - 1);
  localparam logic [IW-1:0] IDLE_LIM  = IW'(TIMEOUT - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [IW-1:0]              idle_q, idle_d;
  logic [DSIZE*NBYTES-1:0]    data_q, data_d;
  logic [NBYTES-1:0]          keep_q, keep_d;
  logic                       pop;

  always_ff @(posedge rclk) begin
    if (rst) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      keep_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    data_d  = data_q;
    keep_d  = keep_q;
    pop     = !rst && (state_q == S_FILL) && !rempty;

    if (state_q == S_FILL) begin
      if (pop) begin
        for (int i = 0; i < NBYTES; i++) begin
          if (cnt_q == CW'(i)) begin
            data_d[i*DSIZE +: DSIZE] = rdata;
            keep_d[i]                = 1'b1;
          end
        end
        cnt_d  = cnt_q + CW'(1);
        idle_d = '0;
        // A flush in a pop cycle closes the word including this entry.
        if ((cnt_q == LAST_LANE) || flush) begin
          state_d = S_HOLD;
        end
      end else if (cnt_q == '0) begin
        // Nothing buffered: no timeout to run and a flush has nothing to emit.
        idle_d = '0;
      end else if (flush || (idle_q == IDLE_LIM)) begin
        state_d = S_HOLD;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end else begin
      if (out_ready) begin
        state_d = S_FILL;
        cnt_d   = '0;
        idle_d  = '0;
        // Clearing the lanes keeps unused lanes of the next partial word at zero.
        data_d  = '0;
        keep_d  = '0;
      end
    end
  end

  assign rinc      = pop;
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = data_q;
  assign out_keep  = keep_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - scoreboard bench for fifo_word_packer
module tb_fifo_word_packer;

  logic        rclk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b1;

  always #5 rclk = ~rclk;

  fifo_word_packer #(.DSIZE(8), .NBYTES(4), .TIMEOUT(16)) dut (
    .rclk      (rclk),
    .rst       (rst),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .flush     (flush),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  logic [7:0]  fifo[$];
  logic [35:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int pop_count = 0;
  int last_pop_cyc = 0;
  int valid_cycles = 0;
  int rise_cyc = 0;
  bit gate = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_hold = 1'b0;
  logic [31:0] hold_data = '0;
  logic [3:0]  hold_keep = '0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic refresh();
    rempty = gate || (fifo.size() == 0);
    rdata  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
    refresh();
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
    exp_q.push_back({k, d});
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    fifo.push_back(b0); fifo.push_back(b1); fifo.push_back(b2); fifo.push_back(b3);
  endtask

  task automatic wait_drain(input int max, input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < max) begin step(); n++; end
    n_checks++;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL %s: %0d words still pending after %0d cycles, required 0", name, exp_q.size(), max);
      exp_q.delete();
    end
  endtask

  task automatic wait_pops(input int target, input int max, input string name);
    int n = 0;
    while (pop_count < target && n < max) begin step(); n++; end
    chk(name, pop_count, target);
  endtask

  task automatic wait_valid(input int max, input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < max) begin step(); n++; end
    chk(name, out_valid, 1'b1);
  endtask

  // FIFO model: the entry leaves at the edge where rinc is high.
  always @(posedge rclk) begin
    cyc++;
    chk("rinc_while_empty", rinc & rempty, 1'b0);
    if (rinc === 1'b1) begin
      pop_count++;
      last_pop_cyc = cyc;
      if (fifo.size() > 0) fifo.delete(0);
    end
  end

  // Monitor: compares accepted words against the scoreboard queue.
  always @(negedge rclk) begin
    if (prev_hold && out_valid === 1'b1)
      chk("hold_stable", {out_keep, out_data}, {hold_keep, hold_data});
    if (out_valid === 1'b1) valid_cycles++;
    if (out_valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    if (out_valid === 1'b1 && out_ready === 1'b1 && rst === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %h required no word", {out_keep, out_data});
      end else begin
        chk("word", {out_keep, out_data}, exp_q.pop_front());
      end
    end
    prev_hold  = (out_valid === 1'b1) && (out_ready !== 1'b1) && (rst === 1'b0);
    hold_data  = out_data;
    hold_keep  = out_keep;
    prev_valid = out_valid;
  end

  initial begin
    int vc0;
    int run;
    logic [31:0] w;
    logic [7:0]  b;

    refresh();
    rst = 1'b1;
    repeat (3) step();
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_keep", out_keep, 4'h0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_rinc", rinc, 1'b0);
    rst = 1'b0;
    refresh();

    // Full word
    pop_count = 0;
    vc0 = valid_cycles;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    expect_word(32'h44332211, 4'b1111);
    refresh();
    wait_drain(20, "full_drain");
    repeat (3) step();
    chk("full_pops", pop_count, 4);
    chk("full_valid_cycles", valid_cycles - vc0, 1);

    // Backpressure
    out_ready = 1'b0;
    pop_count = 0;
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    push4(8'h05, 8'h06, 8'h07, 8'h08);
    expect_word(32'h04030201, 4'b1111);
    expect_word(32'h08070605, 4'b1111);
    refresh();
    repeat (10) step();
    chk("bp_pops_during_hold", pop_count, 4);
    chk("bp_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    wait_drain(30, "bp_drain");
    chk("bp_total_pops", pop_count, 8);

    // Idle timeout
    fifo.push_back(8'hAA);
    fifo.push_back(8'hBB);
    expect_word(32'h0000BBAA, 4'b0011);
    refresh();
    wait_drain(40, "timeout_drain");
    chk("timeout_latency", rise_cyc - last_pop_cyc, 16);

    // Flush together with a pop
    pop_count = 0;
    fifo.push_back(8'h5A);
    fifo.push_back(8'h6B);
    refresh();
    wait_pops(2, 10, "flush_prefill_pops");
    fifo.push_back(8'hCC);
    flush = 1'b1;
    expect_word(32'h00CC6B5A, 4'b0111);
    refresh();
    step();
    flush = 1'b0;
    refresh();
    wait_drain(10, "flush_drain");

    // Flush with nothing buffered
    vc0 = valid_cycles;
    flush = 1'b1;
    repeat (3) step();
    flush = 1'b0;
    repeat (3) step();
    chk("flush_empty_no_valid", valid_cycles - vc0, 0);

    // Reset while holding a word
    out_ready = 1'b0;
    push4(8'h91, 8'h92, 8'h93, 8'h94);
    refresh();
    wait_valid(20, "rst_hold_valid");
    rst = 1'b1;
    refresh();
    #1;
    chk("rst_rinc_comb", rinc, 1'b0);
    step();
    chk("rst_hold_out_valid", out_valid, 1'b0);
    chk("rst_hold_out_keep", out_keep, 4'h0);
    chk("rst_hold_rinc", rinc, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    refresh();

    // Reset after three pops
    pop_count = 0;
    fifo.push_back(8'hA1);
    fifo.push_back(8'hA2);
    fifo.push_back(8'hA3);
    refresh();
    wait_pops(3, 10, "rst_mid_pops");
    rst = 1'b1;
    refresh();
    step();
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_out_keep", out_keep, 4'h0);
    chk("rst_mid_out_data", out_data, 32'h0);
    chk("rst_mid_rinc", rinc, 1'b0);
    rst = 1'b0;
    push4(8'hB1, 8'hB2, 8'hB3, 8'hB4);
    expect_word(32'hB4B3B2B1, 4'b1111);
    refresh();
    wait_drain(20, "rst_mid_drain");

    // Random empty toggling; gaps kept short so no word times out
    for (int i = 0; i < 200; i++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        b = 8'($urandom);
        fifo.push_back(b);
        w[j*8 +: 8] = b;
      end
      expect_word(w, 4'b1111);
    end
    run = 0;
    for (int i = 0; i < 1000; i++) begin
      if (run >= 8) gate = 1'b0;
      else gate = 1'($urandom_range(0, 1));
      run = gate ? run + 1 : 0;
      out_ready = ($urandom_range(0, 3) != 0);
      refresh();
      step();
    end
    gate = 1'b0;
    out_ready = 1'b1;
    refresh();
    wait_drain(1200, "random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
